// File: rtl/screen_sequencer_if.sv
// Bundles the command, grid-scan and display signals of the screen sequencer.
// slave is the sequencer side; master is the IR/game-core/display side.
interface screen_sequencer_if #(
   parameter int ROWS = 16,
   parameter int COLS = 16
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [31:0]          cmd_word;
   logic                 cmd_valid;
   logic                 game_over;
   logic [RW-1:0]        row_addr;
   logic [COLS-1:0]      row_data;
   logic [ROWS*COLS-1:0] disp_grid;
   logic                 frame_update;
   logic                 game_enable;
   logic                 game_reset;
   logic [1:0]           state;

   modport slave (
      input  cmd_word, cmd_valid, game_over, row_data,
      output row_addr, disp_grid, frame_update, game_enable, game_reset, state
   );

   modport master (
      output cmd_word, cmd_valid, game_over, row_data,
      input  row_addr, disp_grid, frame_update, game_enable, game_reset, state
   );
endinterface

// File: rtl/screen_sequencer.sv
// START/PLAY/PAUSE/OVER screen FSM with tear-free row scanner; PAUSE exists only with SCREEN_PAUSE_EN.
// State changes on the edge sampling a command; a frame is published every ROWS cycles; no backpressure.
module screen_sequencer #(
   parameter int                         ROWS       = 16,
   parameter int                         COLS       = 16,
   parameter logic [31:0]                ENTER_CODE = 32'h20DF5AA5,
   parameter logic [31:0]                MENU_CODE  = 32'h20DFC23D,
   parameter logic [ROWS*COLS-1:0]       START_IMG  = '0,
   parameter logic [ROWS*COLS-1:0]       END_IMG    = '0
) (
   input  logic                 CLOCK_50,
   input  logic                 reset_n,
   screen_sequencer_if.slave    bus
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

`ifdef SCREEN_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [RW-1:0]            row_q;
   logic [ROWS-1:0][COLS-1:0] shadow_q, frame_d;
   logic [ROWS*COLS-1:0]     disp_q;
   logic                     frame_upd_q;
   logic                     game_reset_q;
   logic                     enter_cmd, menu_cmd, last_row;

   assign enter_cmd = bus.cmd_valid && (bus.cmd_word == ENTER_CODE);
   assign menu_cmd  = bus.cmd_valid && (bus.cmd_word == MENU_CODE);
   assign last_row  = (row_q == RW'(ROWS - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START: if (enter_cmd) state_d = ST_PLAY;
         ST_PLAY: begin
            if (bus.game_over)               state_d = ST_OVER;
            else if (PAUSE_EN && menu_cmd)   state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
`ifdef SCREEN_PAUSE_EN
            if (bus.game_over)               state_d = ST_OVER;
            else if (menu_cmd || enter_cmd)  state_d = ST_PLAY;
`else
            state_d = ST_START;
`endif
         end
         ST_OVER:  if (enter_cmd) state_d = ST_START;
         default:  state_d = ST_START;
      endcase
   end

   // Completed frame: rows 0..ROWS-2 from the shadow, last row straight from the source.
   always_comb begin
      frame_d           = shadow_q;
      frame_d[ROWS-1]   = bus.row_data;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_q      <= ST_START;
         row_q        <= '0;
         shadow_q     <= '0;
         disp_q       <= START_IMG;
         frame_upd_q  <= 1'b0;
         game_reset_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_upd_q  <= 1'b0;
         game_reset_q <= 1'b0;
         if (state_q == ST_START && state_d == ST_PLAY) begin
            game_reset_q <= 1'b1;
            row_q        <= '0;
            shadow_q     <= '0;
         end else if (state_q == ST_PLAY && state_d == ST_PLAY) begin
            shadow_q[row_q] <= bus.row_data;
            if (last_row) begin
               row_q       <= '0;
               disp_q      <= frame_d;
               frame_upd_q <= 1'b1;
            end else begin
               row_q <= row_q + RW'(1);
            end
         end
         // Screen images override any game frame landing on the same edge.
         if (state_d == ST_OVER && state_q != ST_OVER) begin
            disp_q      <= END_IMG;
            frame_upd_q <= 1'b1;
         end
         if (state_d == ST_START && state_q != ST_START) begin
            disp_q      <= START_IMG;
            frame_upd_q <= 1'b1;
         end
      end
   end

   assign bus.row_addr     = row_q;
   assign bus.disp_grid    = disp_q;
   assign bus.frame_update = frame_upd_q;
   assign bus.game_reset   = game_reset_q;
   assign bus.game_enable  = (state_q == ST_PLAY);
   assign bus.state        = state_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer (ROWS=4, COLS=4); published frames are checked by a scoreboard monitor.
module tb_screen_sequencer;
   localparam logic [31:0] ENTER = 32'h20DF5AA5;
   localparam logic [31:0] MENU  = 32'h20DFC23D;
   localparam logic [15:0] SIMG  = 16'h1234;
   localparam logic [15:0] EIMG  = 16'hDEAD;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [3:0]  src [4];
   logic [15:0] exp_q [$];
   logic [15:0] mon_exp;
   int n_checks = 0;
   int n_pass   = 0;
   int gr_cnt   = 0;

   always #10 clk = ~clk;

   screen_sequencer_if #(.ROWS(4), .COLS(4)) bus ();

   screen_sequencer #(
      .ROWS(4), .COLS(4), .ENTER_CODE(ENTER), .MENU_CODE(MENU),
      .START_IMG(SIMG), .END_IMG(EIMG)
   ) dut (
      .CLOCK_50(clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always_comb bus.row_data = src[bus.row_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every frame_update pulse must match the next queued frame.
   always @(negedge clk) begin
      if (bus.game_reset) gr_cnt++;
      if (bus.frame_update) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL frame_unexpected got=%h expected=no_frame", bus.disp_grid);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("frame", 32'(bus.disp_grid), 32'(mon_exp));
         end
      end
   end

   initial begin
      bus.cmd_word  = '0;
      bus.cmd_valid = 1'b0;
      bus.game_over = 1'b0;
      src[0] = 4'h1; src[1] = 4'h2; src[2] = 4'h4; src[3] = 4'h8;
      repeat (3) tick();
      reset_n = 1'b1;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_disp", 32'(bus.disp_grid), 32'(SIMG));
      chk("rst_enable", 32'(bus.game_enable), 32'd0);
      chk("rst_row", 32'(bus.row_addr), 32'd0);
      chk("rst_greset", 32'(bus.game_reset), 32'd0);
      repeat (2) tick();

      // First play session: ENTER, then ENTER word held with no strobe.
      bus.cmd_word = ENTER; bus.cmd_valid = 1'b1;
      exp_q.push_back(16'h8421); exp_q.push_back(16'h8421); exp_q.push_back(16'h8421);
      tick();
      bus.cmd_valid = 1'b0;
      chk("enter_state", 32'(bus.state), 32'd1);
      chk("enter_greset", 32'(bus.game_reset), 32'd1);
      chk("enter_enable", 32'(bus.game_enable), 32'd1);
      chk("enter_row", 32'(bus.row_addr), 32'd0);
      for (int k = 1; k <= 11; k++) begin
         tick();
         chk("scan_row", 32'(bus.row_addr), 32'(k % 4));
         chk("scan_fupd", 32'(bus.frame_update), 32'((k % 4) == 0));
         if (k == 1) chk("greset_once", 32'(bus.game_reset), 32'd0);
      end
      chk("held_word_state", 32'(bus.state), 32'd1);
      chk("greset_count1", 32'(gr_cnt), 32'd1);

      // Row 2 changes after its capture: current frame intact, next frame shows F.
      src[2] = 4'hF;
      exp_q.push_back(16'h8F21);
      for (int k = 12; k <= 19; k++) begin
         tick();
         chk("mid_fupd", 32'(bus.frame_update), 32'((k % 4) == 0));
      end
      chk("pre_over_row", 32'(bus.row_addr), 32'd3);

      // game_over + MENU on the last-row capture edge: OVER wins, frame dropped.
      bus.game_over = 1'b1; bus.cmd_word = MENU; bus.cmd_valid = 1'b1;
      exp_q.push_back(EIMG);
      tick();
      bus.cmd_valid = 1'b0;
      chk("over_state", 32'(bus.state), 32'd3);
      chk("over_disp", 32'(bus.disp_grid), 32'(EIMG));
      chk("over_enable", 32'(bus.game_enable), 32'd0);
      chk("over_fupd", 32'(bus.frame_update), 32'd1);
      repeat (3) tick();
      chk("over_hold", 32'(bus.state), 32'd3);

      bus.cmd_word = ENTER; bus.cmd_valid = 1'b1;
      exp_q.push_back(SIMG);
      tick();
      bus.cmd_valid = 1'b0;
      chk("restart_state", 32'(bus.state), 32'd0);
      chk("restart_disp", 32'(bus.disp_grid), 32'(SIMG));
      repeat (3) tick();
      chk("start_ignores_go", 32'(bus.state), 32'd0);
      bus.game_over = 1'b0;

      // Second session: MENU mid-frame.
      bus.cmd_word = ENTER; bus.cmd_valid = 1'b1;
      exp_q.push_back(16'h8F21);
      tick();
      bus.cmd_valid = 1'b0;
      chk("s2_state", 32'(bus.state), 32'd1);
      tick();
      chk("greset_count2", 32'(gr_cnt), 32'd2);
      tick();
      chk("s2_row", 32'(bus.row_addr), 32'd2);
      bus.cmd_word = MENU; bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
`ifdef SCREEN_PAUSE_EN
      chk("pause_state", 32'(bus.state), 32'd2);
      chk("pause_enable", 32'(bus.game_enable), 32'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("pause_row", 32'(bus.row_addr), 32'd2);
         chk("pause_disp", 32'(bus.disp_grid), 32'(SIMG));
      end
      chk("pause_hold", 32'(bus.state), 32'd2);
      bus.cmd_word = MENU; bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      chk("resume_state", 32'(bus.state), 32'd1);
      chk("resume_row", 32'(bus.row_addr), 32'd2);
      tick();
      chk("resume_row_next", 32'(bus.row_addr), 32'd3);
      tick();
      chk("resume_frame", 32'(bus.frame_update), 32'd1);
      chk("resume_wrap", 32'(bus.row_addr), 32'd0);
      repeat (2) tick();
`else
      chk("menu_ignored", 32'(bus.state), 32'd1);
      chk("menu_row", 32'(bus.row_addr), 32'd3);
      tick();
      chk("menu_frame", 32'(bus.frame_update), 32'd1);
      repeat (2) tick();
`endif
      chk("midframe_row", 32'(bus.row_addr), 32'd2);

      // Reset mid-frame: back to START with no frame pulse afterwards.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mrst_state", 32'(bus.state), 32'd0);
      chk("mrst_row", 32'(bus.row_addr), 32'd0);
      chk("mrst_disp", 32'(bus.disp_grid), 32'(SIMG));
      chk("mrst_fupd", 32'(bus.frame_update), 32'd0);
      chk("mrst_enable", 32'(bus.game_enable), 32'd0);
      repeat (6) tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Parametrised game-screen sequencer for the LED-matrix snake game. It sits between the IR receiver, the game core and the matrix driver, and runs the START/PLAY/PAUSE/OVER flow from one-shot remote commands. During play it scans the game grid source row by row into a shadow buffer and publishes complete, tear-free frames to the display. In the other states it shows fixed images.

## Interface
Parameters:
- ROWS, 16, grid height in rows; must be ≥ 2.
- COLS, 16, grid width in columns; must be ≥ 1.
- ENTER_CODE, 32'h20DF5AA5, IR word for start/confirm.
- MENU_CODE, 32'h20DFC23D, IR word for pause toggle.
- START_IMG, all zeros, ROWS*COLS-bit start-screen image; row r at [r*COLS +: COLS].
- END_IMG, all zeros, ROWS*COLS-bit game-over image; same layout.

Ports:
- CLOCK_50  in  1  sole clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_word  in  32  last decoded IR word.
- cmd_valid  in  1  one-cycle strobe: cmd_word is a new command.
- game_over  in  1  level from game core.
- row_addr  out  RW  row index presented to grid source; RW = max(1, $clog2(ROWS)).
- row_data  in  COLS  bitmap of row row_addr; combinational from source, same cycle.
- disp_grid  out  ROWS*COLS  displayed frame; same layout as images.
- frame_update  out  1  one-cycle pulse: disp_grid just changed.
- game_enable  out  1  high while state is PLAY.
- game_reset  out  1  one-cycle pulse on entry to PLAY from START.
- state  out  2  START=0, PLAY=1, PAUSE=2, OVER=3.

## Operation
- Commands are acted on only when cmd_valid=1, so a held cmd_word never retriggers. A word matching neither code is ignored.
- FSM:
  - START, on ENTER → PLAY. Pulse game_reset, set row_addr to 0, clear the shadow buffer. game_over is ignored in START.
  - PLAY, on game_over=1 → OVER. game_over has priority over any same-cycle command.
  - PLAY, on MENU → PAUSE (macro only).
  - PAUSE, on MENU or ENTER → PLAY. The scan resumes at the held row_addr.
  - PAUSE, on game_over=1 → OVER, with priority.
  - OVER, on ENTER → START. game_over may remain high.
- Scan in PLAY:
  - Each cycle, capture row_data into shadow[row_addr], then advance row_addr.
  - row_addr wraps from ROWS-1 to 0.
  - On the capture of row ROWS-1, load disp_grid with the shadow rows 0..ROWS-2 plus the row_data being captured, all on the same edge.
  - disp_grid never holds a partially updated frame.
- In PAUSE, row_addr and disp_grid are frozen and no capture occurs.
- Entry to START loads disp_grid with START_IMG; entry to OVER loads it with END_IMG.
- game_enable is decoded from the state register only, so it is glitch-free.
- Reset values: state=START, disp_grid=START_IMG, row_addr=0, frame_update=0, game_reset=0, game_enable=0, shadow=0.
- A reset asserted mid-scan or mid-frame discards the shadow buffer. No frame_update pulse follows reset.

## Timing
- Command to state change: the state register updates on the edge that samples cmd_valid=1. Outputs derived from state follow in the next cycle.
- game_reset goes high in the cycle immediately after the START→PLAY edge, for exactly 1 cycle.
- Frame period in PLAY is exactly ROWS cycles.
- frame_update is high for 1 cycle, in the same cycle the new disp_grid is first visible. It also pulses on entry to START and entry to OVER.
- A row_data change is reflected in disp_grid within 2*ROWS cycles while in PLAY.
- First frame after entering PLAY: frame_update fires ROWS cycles after game_reset.
- If game_over rises on the same edge as the row ROWS-1 capture, OVER wins. disp_grid is set to END_IMG and the game frame is dropped.

## Configuration
- SCREEN_PAUSE_EN defined: PAUSE state present; MENU toggles PLAY↔PAUSE as above.
- SCREEN_PAUSE_EN undefined:
  - MENU is ignored in every state and PAUSE is unreachable.
  - The state encoding stays 2 bits.
  - A state of 2 is treated as START on the next edge.

## Test plan
- Reset, then ENTER strobe:
  - After reset: state=0, disp_grid=START_IMG, game_enable=0.
  - After ENTER: state=1, one game_reset pulse, game_enable=1.
  - cmd_word held at ENTER for 10 cycles with cmd_valid low: no further transitions.
- PLAY, ROWS=4, COLS=4, source returns row r = 4'h1<<r:
  - disp_grid=16'h8421 after 4 cycles, one frame_update pulse.
  - Pulses repeat every 4 cycles.
  - row_addr sequence 0,1,2,3,0.
- Change the source mid-frame (row 2 → 4'hF while row_addr=3): the current frame is unaffected, and the next frame shows row 2 = F. No torn frame is ever output.
- game_over=1 together with MENU and cmd_valid, on the last-row capture edge: state=3, disp_grid=END_IMG, no game frame published.
- SCREEN_PAUSE_EN defined:
  - MENU in PLAY → state=2; disp_grid and row_addr held for 20 cycles.
  - MENU again → PLAY, scan continues from the held row.
- SCREEN_PAUSE_EN undefined: MENU in PLAY leaves state=1. Reset asserted mid-frame → state=0, row_addr=0, shadow cleared.
